// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit, its PC mux,
// the control decoder and the bench.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OP_W-1:0] OP_J     = 6'd2;
  localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd8;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'd10;
  localparam logic [OP_W-1:0] OP_LW    = 6'd35;
  localparam logic [OP_W-1:0] OP_SW    = 6'd43;

  function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1:INSTR_W-OP_W];
  endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC selection: hold, sequential +4, or word-aligned redirect.
module fetch_pc_next
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [1:0]        sel,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] pc_next
);

  assign pc_plus4 = pc + ADDR_W'(4);

  always_comb begin
    pc_next = pc;
    case (sel)
      PC_INC:   pc_next = pc_plus4;
      PC_REDIR: pc_next = {redirect_pc[ADDR_W-1:2], 2'b00};
      default:  pc_next = pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetcher feeding decode over valid/ready,
// with redirect support and dropping of responses made stale by a redirect.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_n,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [OP_W-1:0]    instr_op_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  pc_plus4_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [31:0]        fetch_cnt_o
);

  state_e            state;
  logic              drop;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] pc_next;
  pc_sel_e           pc_sel;

  // A redirect always wins; otherwise pc only advances on an accepted response.
  always_comb begin
    pc_sel = PC_HOLD;
    if (redirect_i) begin
      pc_sel = PC_REDIR;
    end else if (state == WAIT && imem_rvalid_i && !drop) begin
      pc_sel = PC_INC;
    end
  end

  fetch_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .sel         (pc_sel),
    .pc          (pc),
    .redirect_pc (redirect_pc_i),
    .pc_plus4    (pc_plus4),
    .pc_next     (pc_next)
  );

  // Request is suppressed during reset and in a redirect cycle.
  assign imem_req_o  = rst_n & (state == FETCH) & ~redirect_i;
  assign imem_addr_o = pc;
  assign instr_op_o  = opcode_of(instr_o);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      drop        <= 1'b0;
      pc          <= RESET_PC;
      valid_o     <= 1'b0;
      instr_o     <= '0;
      pc_o        <= '0;
      pc_plus4_o  <= '0;
      fetch_cnt_o <= '0;
    end else begin
      pc <= pc_next;
      case (state)
        FETCH: begin
          if (!redirect_i && imem_gnt_i) state <= WAIT;
        end
        WAIT: begin
          if (redirect_i) begin
            // A response landing with the redirect is stale; otherwise mark the next one.
            if (imem_rvalid_i) begin
              drop  <= 1'b0;
              state <= FETCH;
            end else begin
              drop  <= 1'b1;
            end
          end else if (imem_rvalid_i) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= FETCH;
            end else begin
              instr_o    <= imem_rdata_i;
              pc_o       <= pc;
              pc_plus4_o <= pc_plus4;
              valid_o    <= 1'b1;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect_i) begin
            valid_o <= 1'b0;
            state   <= FETCH;
          end else if (ready_i) begin
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
            valid_o     <= 1'b0;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
